// File: rtl/tablero_juego.sv
// tablero_juego: tic-tac-toe board controller fed by synchronised per-cell strobes.
// Optional turn timeout is built only when TURN_TIMEOUT_EN is defined.
module tablero_juego #(
  parameter int unsigned TIMEOUT_CICLOS = 250000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  casillas,
  input  logic        reiniciar,
  output logic [17:0] tablero,
  output logic        turno,
  output logic [1:0]  ganador,
  output logic        empate,
  output logic        jugada_valida,
  output logic        jugada_invalida,
  output logic        timeout_turno
);

  typedef enum logic [1:0] {ESPERA, EVALUA, FIN} estado_e;

  estado_e     estado_q;
  logic [8:0]  sync1_q, sync2_q, prev_q, armado_q;
  logic [1:0]  llenado_q;
  logic [17:0] tablero_q;
  logic        turno_q, empate_q;
  logic [1:0]  ganador_q;
  logic        valida_q, invalida_q, timeout_q;

  logic [8:0]  flanco, ocupadas;
  logic [17:0] escritura;
  logic [1:0]  marca;
  logic        jug_ok, jug_mal, expira;

  function automatic logic hay_linea(input logic [17:0] t, input logic [1:0] m);
    logic [8:0] p;
    for (int i = 0; i < 9; i++) p[i] = (t[2*i +: 2] == m);
    return (p[0] & p[1] & p[2]) | (p[3] & p[4] & p[5]) | (p[6] & p[7] & p[8]) |
           (p[0] & p[3] & p[6]) | (p[1] & p[4] & p[7]) | (p[2] & p[5] & p[8]) |
           (p[0] & p[4] & p[8]) | (p[2] & p[4] & p[6]);
  endfunction

  // A bit only arms once the filled pipeline has seen it low, so a strobe
  // held across reset cannot count until it is released and pressed again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      armado_q  <= '0;
      llenado_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync1_q   <= casillas;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      llenado_q <= {llenado_q[0], 1'b1};
      if (llenado_q[1]) armado_q <= armado_q | ~sync2_q;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    ocupadas  = '0;
    escritura = '0;
    marca     = turno_q ? 2'b10 : 2'b01;
    flanco    = sync2_q & ~prev_q & armado_q;
    for (int i = 0; i < 9; i++) begin
      ocupadas[i]         = |tablero_q[2*i +: 2];
      escritura[2*i +: 2] = flanco[i] ? marca : 2'b00;
    end
    jug_ok  = (estado_q == ESPERA) && $onehot(flanco) && ((flanco & ocupadas) == '0);
    jug_mal = (estado_q == ESPERA) && (flanco != '0) && !jug_ok;
  end

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CICLOS - 1);

  logic [CNT_W-1:0] cuenta_q;

  assign expira = (estado_q == ESPERA) && (cuenta_q == CNT_MAX);

  // An invalid move landing on the expiry cycle holds the count so expiry fires next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta_q <= '0;
    end else if (reiniciar || jug_ok || (expira && !jug_mal)) begin
      cuenta_q <= '0;
    end else if (estado_q == ESPERA && !expira) begin
      cuenta_q <= cuenta_q + 1'b1;
    end
  end
`else
  // Parameter kept on the interface; without the timeout feature it has no effect.
  assign expira = (TIMEOUT_CICLOS == 0) && 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q   <= ESPERA;
      tablero_q  <= '0;
      turno_q    <= 1'b0;
      ganador_q  <= 2'b00;
      empate_q   <= 1'b0;
      valida_q   <= 1'b0;
      invalida_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      valida_q   <= 1'b0;
      invalida_q <= 1'b0;
      timeout_q  <= 1'b0;
      if (reiniciar) begin
        estado_q  <= ESPERA;
        tablero_q <= '0;
        turno_q   <= 1'b0;
        ganador_q <= 2'b00;
        empate_q  <= 1'b0;
      end else begin
        case (estado_q)
          ESPERA: begin
            if (jug_ok) begin
              tablero_q <= tablero_q | escritura;
              valida_q  <= 1'b1;
              estado_q  <= EVALUA;
            end else if (jug_mal) begin
              invalida_q <= 1'b1;
            end else if (expira) begin
              turno_q   <= ~turno_q;
              timeout_q <= 1'b1;
            end
          end
          EVALUA: begin
            if (hay_linea(tablero_q, marca)) begin
              ganador_q <= marca;
              estado_q  <= FIN;
            end else if (&ocupadas) begin
              empate_q <= 1'b1;
              estado_q <= FIN;
            end else begin
              turno_q  <= ~turno_q;
              estado_q <= ESPERA;
            end
          end
          FIN:     estado_q <= FIN;
          default: estado_q <= ESPERA;
        endcase
      end
    end
  end

  assign tablero         = tablero_q;
  assign turno           = turno_q;
  assign ganador         = ganador_q;
  assign empate          = empate_q;
  assign jugada_valida   = valida_q;
  assign jugada_invalida = invalida_q;
  assign timeout_turno   = timeout_q;

endmodule

// File: doc/tablero_juego.md
TABLERO_JUEGO -- requirements
Module: tablero_juego

Interface
REQ-001 Parameter TIMEOUT_CICLOS, default 250000000, turn-timeout length in clock cycles (used only with TURN_TIMEOUT_EN).
REQ-002 clk  in  1  single system clock, rising-edge active.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 casillas  in  9  per-cell strobes from the position/button decoder; bit i = cell i (0..8), level-high while the button is held.
REQ-005 reiniciar  in  1  synchronous new-game request, level, sampled each clk.
REQ-006 tablero  out  18  board state; bits [2i+1:2i] = cell i: 00 empty, 01 X, 10 O, 11 never driven.
REQ-007 turno  out  1  player to move: 0 = X, 1 = O.
REQ-008 ganador  out  2  00 none, 01 X won, 10 O won.
REQ-009 empate  out  1  board full with no winner.
REQ-010 jugada_valida  out  1  one-cycle pulse when a mark is written.
REQ-011 jugada_invalida  out  1  one-cycle pulse when a move is rejected.
REQ-012 timeout_turno  out  1  one-cycle pulse when a turn expires.

Function
REQ-013 casillas SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected as sync2 & ~prev, with prev registered from sync2.
REQ-014 FSM states: ESPERA (await move), EVALUA (check result), FIN (game over).
REQ-015 In ESPERA, exactly one rising bit on an empty cell SHALL write the turno mark into that cell, pulse jugada_valida on the same edge, and enter EVALUA.
REQ-016 Board update SHALL occur on the 3rd rising clk edge after casillas rises; turno/ganador/empate SHALL update on the 4th.
REQ-017 In ESPERA, a rising bit on an occupied cell, or more than one rising bit in the same cycle, SHALL pulse jugada_invalida with no board or turn change.
REQ-018 A held strobe SHALL produce only one move; re-arming requires the synchronized bit to return low.
REQ-019 EVALUA (one cycle) SHALL check all 8 lines (3 rows, 3 columns, 2 diagonals): a line of the current mark sets ganador and goes to FIN; else all 9 cells full sets empate and goes to FIN; else turno toggles and goes to ESPERA.
REQ-020 A win on the 9th mark SHALL report ganador, not empate.
REQ-021 Strobe edges arriving in EVALUA or FIN SHALL be ignored (no pulses); edge-detect registers keep updating.
REQ-022 reiniciar SHALL clear tablero, turno, ganador and empate and enter ESPERA on the next edge from any state, with priority over a simultaneous strobe edge.
REQ-023 jugada_valida, jugada_invalida and timeout_turno SHALL be mutually exclusive in any cycle.

Reset
REQ-024 rst asserted SHALL immediately force: tablero=0, turno=0, ganador=00, empate=0, all pulses 0, state ESPERA, synchronizer/prev regs 0, timeout counter 0.
REQ-025 rst mid-move (strobe in synchronizer pipeline) SHALL discard the move; a strobe still high after rst release SHALL not count until it goes low and rises again.

Configuration
REQ-026 Macro TURN_TIMEOUT_EN: defined, a counter SHALL increment every cycle in ESPERA, clear on valid move, reiniciar or turn expiry, and at count TIMEOUT_CICLOS-1 toggle turno and pulse timeout_turno; invalid moves do not clear it.
REQ-027 Undefined: no counter is built, turno changes only via EVALUA/reiniciar, and timeout_turno is tied to 0 (port retained).
REQ-028 Valid-move write and expiry in the same cycle: the move SHALL win and the counter clears.

Verification
REQ-029 After rst, casillas=9'h010 high 5 cycles -> tablero=18'h00100, jugada_valida one pulse at edge 3, turno=1 at edge 4.
REQ-030 X on 0,4,8 with O on 1,2 (alternating, valid) -> ganador=01 after 5th mark's EVALUA; further strobes give no pulses; reiniciar -> tablero=0, turno=0, ganador=00.
REQ-031 Strobe cell 4 twice (second by O) -> second gives jugada_invalida pulse, tablero unchanged, turno stays 1.
REQ-032 casillas=9'h003 rising together -> jugada_invalida, tablero=0, turno=0.
REQ-033 Sequence X0,O1,X2,O4,X3,O5,X7,O6,X8 -> empate=1, ganador=00, state FIN.
REQ-034 TURN_TIMEOUT_EN, TIMEOUT_CICLOS=16, no input -> timeout_turno pulses at cycle 16 after rst release, turno=1; without macro turno stays 0 for 100 cycles.
